uart_tx_core: RTL and testbench



---
 rtl/uart_tx_core.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//
// UART transmit serializer. A word is accepted on tx_start while IDLE and
// shifted out LSB-first as: start bit, DATA_BITS data bits, optional
// even-parity bit, STOP_BITS stop bits. Every bit boundary is set by the
// external one-clock baud_tick pulse, so the frame is aligned to the baud grid.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// (PARITY state, encoding 5) between the last data bit and the stop bit(s).
//
// Parameters:
//   DATA_BITS     data word width, 5..9 (default 8)
//   STOP_BITS     number of stop-bit periods, 1 or 2 (default 1)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   enable        block enable; low aborts any frame and holds IDLE
//   baud_tick     one-clock pulse per bit period
//   data_in       word to send, captured when a start is accepted
//   tx_start      start request, honoured only in IDLE
//   tx            serial line, idles high
//   busy          high in START_BIT, DATA, PARITY and STOP
//   done          one-clock pulse when a frame completes normally
//   dbg_tx_state  current FSM state encoding
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_tx_state
);

    localparam int IDX_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4,
        S_PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic [1:0]           stop_cnt;
`ifdef UART_TX_PARITY_EN
    // Parity is computed from the word at acceptance, because the shift
    // register no longer holds the whole word by the time it is needed.
    logic                 parity_bit;
`endif

    assign dbg_tx_state = state;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register is small and reset explicitly so the
            // datapath starts from a known value; large memories would not be.
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_cnt  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (!enable) begin
            // Abort: silent return to IDLE, no done pulse for the lost frame.
            state    <= S_IDLE;
            bit_idx  <= '0;
            stop_cnt <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    // A coincident baud_tick is deliberately not used here:
                    // the start bit waits for the next tick in S_START.
                    if (tx_start) begin
                        shift_reg <= data_in;
                        bit_idx   <= '0;
                        stop_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                    end
                end

                S_START: begin
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (baud_tick) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        tx    <= parity_bit;
                        state <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (baud_tick) begin
                        tx <= 1'b1;
                        // Leaving on the tick that starts the last stop bit is
                        // safe: a new start bit can only go out on a later tick.
                        if (stop_cnt == 2'(STOP_BITS - 1)) begin
                            stop_cnt <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
//
// Self-checking bench for uart_tx_core (DATA_BITS=8, STOP_BITS=1). Expected
// frames come from a list-of-bits reference model and from hand-written
// constants. Honours UART_TX_PARITY_EN when defined at compile time.
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 baud_tick;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx_start;
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic [2:0]           dbg_tx_state;

    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;

    uart_tx_core #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .baud_tick    (baud_tick),
        .data_in      (data_in),
        .tx_start     (tx_start),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .dbg_tx_state (dbg_tx_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame_np;  // tx sequence without parity, bit 0 first
        logic       par;       // even-parity bit of data
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    // Reference frame: list of line levels, one per baud tick, in send order.
    function automatic logic [15:0] model_frame(input logic [DATA_BITS-1:0] d);
        logic [15:0] f;
        int k;
        f = '0;
        k = 0;
        f[k] = 1'b0;
        k++;
        for (int i = 0; i < DATA_BITS; i++) begin
            f[k] = d[i];
            k++;
        end
        if (PAR_BITS == 1) begin
            f[k] = ($countones(d) % 2) == 1;
            k++;
        end
        for (int i = 0; i < STOP_BITS; i++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    // Accept a word, then supply FRAME_LEN ticks spaced 'gap' clocks apart,
    // checking tx after each tick and its stability between ticks.
    task automatic send_frame(input logic [7:0] d, input int gap, input logic tick_at_start,
                              output logic [15:0] got);
        logic [15:0] exp;
        logic        prev;
        exp = model_frame(d);
        data_in   = d;
        tx_start  = 1'b1;
        baud_tick = tick_at_start;
        step();
        tx_start  = 1'b0;
        baud_tick = 1'b0;
        data_in   = 8'($urandom);
        check("accept_busy", busy, 1);
        check("accept_state", dbg_tx_state, 1);
        check("accept_tx", tx, 1);
        prev = 1'b1;
        got  = '0;
        for (int b = 0; b < FRAME_LEN; b++) begin
            for (int g = 1; g < gap; g++) begin
                step();
                check("tx_hold", tx, prev);
            end
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            got[b] = tx;
            check("tx_bit", tx, exp[b]);
            prev = tx;
            if (b == FRAME_LEN - 1) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("state_done", dbg_tx_state, 4);
            end else begin
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
            end
        end
        // A tick while in DONE must be ignored.
        baud_tick = 1'($urandom_range(0, 1));
        step();
        baud_tick = 1'b0;
        check("end_state", dbg_tx_state, 0);
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("end_tx", tx, 1);
    endtask

    initial begin
        logic [15:0] got;
        int d0;
        int ticks;
        logic [7:0] rd;

        vecs[0] = '{8'hAA, 10'h354, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h12, 10'h224, 1'b0};
        vecs[4] = '{8'h34, 10'h268, 1'b1};
        vecs[5] = '{8'h56, 10'h2AC, 1'b0};
        vecs[6] = '{8'hA1, 10'h342, 1'b1};

        rst = 1'b1; enable = 1'b0; baud_tick = 1'b0; data_in = '0; tx_start = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_tx_state, 0);
        step();
        rst = 1'b0;

        // Disabled: start requests are ignored.
        data_in = 8'hA5; tx_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("dis_tx", tx, 1);
            check("dis_busy", busy, 0);
            check("dis_state", dbg_tx_state, 0);
        end
        tx_start = 1'b0;
        enable = 1'b1;
        step();

        // 0x55 with one tick per 16 clocks.
        d0 = done_seen;
        send_frame(8'h55, 16, 1'b0, got);
`ifdef UART_TX_PARITY_EN
        check("frame_55", got[10:0], 11'h4AA);
`else
        check("frame_55", got[9:0], 10'h2AA);
`endif
        check("done_cnt_55", done_seen - d0, 1);

        // Back-to-back table words.
        for (int v = 0; v < 7; v++) begin
            d0 = done_seen;
            send_frame(vecs[v].data, 3, 1'b0, got);
            check("tbl_word", got[8:1], vecs[v].data);
`ifdef UART_TX_PARITY_EN
            check("tbl_parity", got[9], vecs[v].par);
            check("tbl_stop", got[10], 1);
`else
            check("tbl_frame", got[9:0], vecs[v].frame_np);
`endif
            check("tbl_done_cnt", done_seen - d0, 1);
        end

        // Single-cycle start, ticks supplied until busy drops (bounded).
        d0 = done_seen;
        data_in = 8'hA1; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        check("a1_busy", busy, 1);
        ticks = 0;
        got = '0;
        while (busy && ticks < 40) begin
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            got[ticks[3:0]] = tx;
            ticks++;
            if (busy) step();
        end
        check("a1_ticks", ticks, FRAME_LEN);
        check("a1_word", got[8:1], 8'hA1);
        step();
        check("a1_idle", dbg_tx_state, 0);
        check("a1_done_cnt", done_seen - d0, 1);

        // Abort after two ticks, then a normal frame.
        d0 = done_seen;
        data_in = 8'hB2; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            baud_tick = 1'b1; step(); baud_tick = 1'b0; step();
        end
        enable = 1'b0;
        step();
        check("abort_busy", busy, 0);
        check("abort_tx", tx, 1);
        check("abort_state", dbg_tx_state, 0);
        baud_tick = 1'b1; step(); baud_tick = 1'b0; step();
        check("abort_no_done", done_seen - d0, 0);
        enable = 1'b1;
        step();
        send_frame(8'h3C, 2, 1'b0, got);
        check("reenable_word", got[8:1], 8'h3C);

        // Start coincident with a tick: tick not used as the start-bit tick.
        send_frame(8'h9E, 2, 1'b1, got);
        check("coinc_word", got[8:1], 8'h9E);

`ifdef UART_TX_PARITY_EN
        send_frame(8'h07, 4, 1'b0, got);
        check("par07_tick10", got[9], 1);
        check("par07_tick11", got[10], 1);
`endif

        // Random frames with random idle gaps and stray ticks in IDLE.
        for (int r = 0; r < 25; r++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                baud_tick = 1'($urandom_range(0, 1));
                step();
                baud_tick = 1'b0;
                check("rnd_idle_tx", tx, 1);
                check("rnd_idle_state", dbg_tx_state, 0);
            end
            rd = 8'($urandom);
            d0 = done_seen;
            send_frame(rd, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), got);
            check("rnd_word", got[8:1], rd);
            check("rnd_done_cnt", done_seen - d0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
